// File: rtl/breadboard_sweeper_if.sv
// Handshake and pin bundle between the truth-table sweeper and its controller/breadboard.
// The master side drives the requests and breadboard outputs; the slave is the sweeper.
interface breadboard_sweeper_if;
    logic       start;
    logic       abort;
    logic [3:0] first;
    logic [3:0] last;
    logic       w;
    logic       x;
    logic       y;
    logic       z;
    logic [9:0] f;
    logic       row_valid;
    logic       row_ready;
    logic [3:0] row_idx;
    logic [9:0] row_f;
    logic [9:0] sig;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, first, last, f, row_ready,
        input  w, x, y, z, row_valid, row_idx, row_f, sig, busy, done
    );

    modport slave (
        input  start, abort, first, last, f, row_ready,
        output w, x, y, z, row_valid, row_idx, row_f, sig, busy, done
    );
endinterface

// File: rtl/breadboard_sweeper.sv
// Walks a range of 4-bit truth-table rows, lets the breadboard settle, captures f per row,
// presents each row on a valid/ready handshake and folds accepted rows into a signature.
module breadboard_sweeper #(
    parameter int unsigned SETTLE = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    breadboard_sweeper_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StSettle, StOut, StDone} state_t;

    localparam logic [3:0] Reload = 4'(SETTLE - 1);

    state_t     state_q;
    logic [3:0] idx_q;
    logic [3:0] last_q;
    logic [3:0] cnt_q;
    logic [3:0] row_idx_q;
    logic [9:0] row_f_q;
    logic [9:0] sig_q;
    logic       row_valid_q;
    logic       busy_q;
    logic       done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            row_idx_q   <= '0;
            row_f_q     <= '0;
            sig_q       <= '0;
            row_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (bus.abort && state_q != StIdle) begin
            // Cancel keeps idx (pins hold) and sig, drops everything visible.
            state_q     <= StIdle;
            row_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        idx_q   <= bus.first;
                        last_q  <= bus.last;
                        sig_q   <= '0;
                        cnt_q   <= Reload;
                        busy_q  <= 1'b1;
                        state_q <= StSettle;
                    end
                end
                StSettle: begin
                    if (cnt_q == 4'd0) begin
                        row_f_q     <= bus.f;
                        row_idx_q   <= idx_q;
                        row_valid_q <= 1'b1;
                        state_q     <= StOut;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StOut: begin
                    if (bus.row_ready) begin
                        sig_q       <= {sig_q[8:0], sig_q[9]} ^ row_f_q;
                        row_valid_q <= 1'b0;
                        if (idx_q == last_q) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            cnt_q   <= Reload;
                            state_q <= StSettle;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign {bus.w, bus.x, bus.y, bus.z} = idx_q;
    assign bus.row_valid = row_valid_q;
    assign bus.row_idx   = row_idx_q;
    assign bus.row_f     = row_f_q;
    assign bus.sig       = sig_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_breadboard_sweeper.sv
// Directed bench for breadboard_sweeper: a fixed breadboard truth table drives f from the
// pins, and each step checks timing, captured rows and signatures against hand values.
module tb_breadboard_sweeper;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;

    breadboard_sweeper_if bus ();

    breadboard_sweeper #(.SETTLE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] wxyz;
    assign wxyz = {bus.w, bus.x, bus.y, bus.z};

    function automatic logic [9:0] bb(input logic [3:0] r);
        case (r)
            4'd0:  bb = 10'h363;
            4'd1:  bb = 10'h0A5;
            4'd2:  bb = 10'h1C4;
            4'd3:  bb = 10'h27B;
            4'd4:  bb = 10'h3F0;
            4'd5:  bb = 10'h2F1;
            4'd6:  bb = 10'h155;
            4'd7:  bb = 10'h0CC;
            4'd8:  bb = 10'h2AA;
            4'd9:  bb = 10'h111;
            4'd10: bb = 10'h3E8;
            4'd11: bb = 10'h07F;
            4'd12: bb = 10'h200;
            4'd13: bb = 10'h1B6;
            4'd14: bb = 10'h2D2;
            default: bb = 10'h01E;
        endcase
    endfunction

    assign bus.f = bb(wxyz);

    function automatic logic [9:0] sig_model(input logic [3:0] a, input logic [3:0] b);
        logic [9:0] s = '0;
        logic [3:0] i = a;
        for (int k = 0; k < 16; k++) begin
            s = {s[8:0], s[9]} ^ bb(i);
            if (i == b) break;
            i = i + 4'd1;
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.row_valid && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.row_valid), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!bus.done && n < 80) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.done), 32'd1);
    endtask

    task automatic go(input logic [3:0] a, input logic [3:0] b);
        bus.first = a;
        bus.last  = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    int c;
    int rows;
    int last_hs;
    int done_cyc;
    int busy_low;
    int seq_err;
    logic [3:0]  exp_idx;
    logic [3:0]  held_idx;
    logic [9:0]  held_f;
    logic [9:0]  held_sig;
    bit          saw_done;

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.first     = 4'd0;
        bus.last      = 4'd0;
        bus.row_ready = 1'b1;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.row_valid), 32'd0);
        check("rst_sig", 32'(bus.sig), 32'd0);
        check("rst_pins", 32'(wxyz), 32'd0);
        check("rst_done_idx_f", {bus.done, bus.row_idx, bus.row_f}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single row 0: valid at cycle 3, done at cycle 4
        go(4'd0, 4'd0);
        check("r0_busy_c1", 32'(bus.busy), 32'd1);
        tick();
        check("r0_novalid_c2", 32'(bus.row_valid), 32'd0);
        tick();
        check("r0_valid_c3", 32'(bus.row_valid), 32'd1);
        check("r0_idx", 32'(bus.row_idx), 32'd0);
        check("r0_f", 32'(bus.row_f), 32'h363);
        tick();
        check("r0_done_c4", 32'(bus.done), 32'd1);
        check("r0_sig", 32'(bus.sig), 32'h363);
        check("r0_valid_low", 32'(bus.row_valid), 32'd0);
        tick();
        check("r0_done_pulse", 32'(bus.done), 32'd0);
        check("r0_idle", 32'(bus.busy), 32'd0);

        // Single row 5
        go(4'd5, 4'd5);
        wait_valid("r5_wait");
        check("r5_idx", 32'(bus.row_idx), 32'd5);
        check("r5_f", 32'(bus.row_f), 32'h2F1);
        tick();
        check("r5_sig", 32'(bus.sig), 32'h2F1);
        check("r5_done", 32'(bus.done), 32'd1);
        tick();
        check("r5_pins_hold", 32'(wxyz), 32'd5);

        // Wrap 15 -> 0
        go(4'd15, 4'd0);
        wait_valid("wrap_wait15");
        check("wrap_idx15", 32'(bus.row_idx), 32'd15);
        check("wrap_f15", 32'(bus.row_f), 32'h01E);
        tick();
        wait_valid("wrap_wait0");
        check("wrap_idx0", 32'(bus.row_idx), 32'd0);
        check("wrap_f0", 32'(bus.row_f), 32'h363);
        tick();
        check("wrap_done", 32'(bus.done), 32'd1);
        check("wrap_sig", 32'(bus.sig), 32'h35F);
        tick();

        // Full sweep timing from start at cycle 0
        bus.first = 4'd0;
        bus.last  = 4'd15;
        bus.start = 1'b1;
        rows = 0; last_hs = -1; done_cyc = -1; busy_low = -1; seq_err = 0; exp_idx = 4'd0;
        for (c = 1; c <= 60; c++) begin
            tick();
            bus.start = 1'b0;
            if (bus.row_valid) begin
                if (bus.row_idx != exp_idx || bus.row_f != bb(exp_idx)) seq_err++;
                exp_idx = exp_idx + 4'd1;
                rows++;
                last_hs = c;
            end
            if (bus.done) done_cyc = c;
            if (!bus.busy && busy_low < 0) busy_low = c;
        end
        check("full_rows", 32'(rows), 32'd16);
        check("full_seq", 32'(seq_err), 32'd0);
        check("full_last_hs", 32'(last_hs), 32'd48);
        check("full_done_cyc", 32'(done_cyc), 32'd49);
        check("full_busy_low", 32'(busy_low), 32'd50);
        check("full_sig", 32'(bus.sig), 32'(sig_model(4'd0, 4'd15)));

        // Back-pressure: hold row 2 for 5 cycles while start pulses arrive
        bus.row_ready = 1'b0;
        go(4'd2, 4'd3);
        wait_valid("bp_wait");
        held_idx = bus.row_idx;
        held_f   = bus.row_f;
        seq_err  = 0;
        for (int k = 0; k < 5; k++) begin
            bus.first = 4'd9;
            bus.start = k[0];
            tick();
            if (!bus.row_valid || bus.row_idx != held_idx || bus.row_f != held_f ||
                wxyz != 4'd2) seq_err++;
        end
        bus.start = 1'b0;
        check("bp_idx", 32'(held_idx), 32'd2);
        check("bp_f", 32'(held_f), 32'h1C4);
        check("bp_stable", 32'(seq_err), 32'd0);
        bus.row_ready = 1'b1;
        wait_done("bp_done");
        check("bp_sig", 32'(bus.sig), 32'(sig_model(4'd2, 4'd3)));
        tick();

        // Abort during the settle of row 3
        go(4'd0, 4'd7);
        c = 0;
        while (!(wxyz == 4'd3 && bus.busy && !bus.row_valid) && c < 40) begin
            tick();
            c++;
        end
        check("ab_reach_row3", 32'(wxyz), 32'd3);
        held_sig = bus.sig;
        check("ab_sig_before", 32'(held_sig), 32'(sig_model(4'd0, 4'd2)));
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("ab_idle", 32'(bus.busy), 32'd0);
        check("ab_valid", 32'(bus.row_valid), 32'd0);
        saw_done = bus.done;
        for (int k = 0; k < 8; k++) begin
            tick();
            saw_done |= bus.done;
        end
        check("ab_no_done", 32'(saw_done), 32'd0);
        check("ab_sig_hold", 32'(bus.sig), 32'(held_sig));
        check("ab_pins_hold", 32'(wxyz), 32'd3);

        // Abort beats start in IDLE
        bus.abort = 1'b1;
        go(4'd1, 4'd1);
        bus.abort = 1'b0;
        check("ab_start_ignored", 32'(bus.busy), 32'd0);
        tick();
        check("ab_start_novalid", 32'(bus.busy), 32'd0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("ab_rst_sig", 32'(bus.sig), 32'd0);
        check("ab_rst_pins", 32'(wxyz), 32'd0);

        // Reset mid-sweep discards it with no done pulse
        go(4'd4, 4'd6);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            saw_done |= bus.done | bus.busy;
            tick();
        end
        check("mid_rst_quiet", 32'(saw_done), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
